// File: rtl/foreground_vram_arbiter_pkg.sv
// Shared types for the foreground VRAM arbiter: slot ownership and the read-return tags.
package fg_pkg;

    typedef enum logic {
        OWN_DISP,
        OWN_CPU
    } slot_owner_t;

    typedef enum logic [1:0] {
        TAG_NONE,
        TAG_DISP,
        TAG_CPU
    } rd_tag_t;

    localparam int FG_CELL_SLOTS = 8;

endpackage

// File: rtl/foreground_vram_arbiter_rd_tag_pipe.sv
// Delays the owner tag of each issued VRAM access so it lines up with the returning read data.
module fg_rd_tag_pipe
    import fg_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic    clk_i,
    input  logic    rst_ni,
    input  rd_tag_t tag_i,
    output rd_tag_t tag_o
);

    rd_tag_t pipe_q [DEPTH];
    rd_tag_t pipe_d [DEPTH];

    always_comb begin
        pipe_d[0] = tag_i;
        for (int i = 1; i < DEPTH; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // Reset flushes in-flight tags so no stale valid pulse appears after release.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= TAG_NONE;
            end
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/foreground_vram_arbiter.sv
// Slot scheduler sharing the single-port foreground VRAM between display fetch and the CPU port.
module foreground_vram_arbiter
    import fg_pkg::*;
#(
    parameter int AW         = 14,
    parameter int DW         = 8,
    parameter int RD_LAT     = 1,
    parameter int DISP_SLOTS = 2
) (
    input  logic          I_pxl_clk,
    input  logic          I_rst_n,
    input  logic          I_line_start,
    input  logic          I_active,
    input  logic [AW-1:0] I_disp_addr,
    output logic          O_disp_valid,
    output logic [DW-1:0] O_disp_data,
    input  logic          I_cpu_req,
    input  logic          I_cpu_we,
    input  logic [AW-1:0] I_cpu_addr,
    input  logic [DW-1:0] I_cpu_wdata,
    output logic          O_cpu_ack,
    output logic          O_cpu_rvalid,
    output logic [DW-1:0] O_cpu_rdata,
    output logic          O_vram_ce,
    output logic          O_vram_we,
    output logic [AW-1:0] O_vram_addr,
    output logic [DW-1:0] O_vram_wdata,
    input  logic [DW-1:0] I_vram_rdata
);

    localparam int                SLOT_W   = $clog2(FG_CELL_SLOTS);
    localparam logic [SLOT_W-1:0] DISP_LIM = SLOT_W'(DISP_SLOTS);

    logic [SLOT_W-1:0] slot_q, slot_d;
    slot_owner_t       owner;
    logic              grant;
    logic              ce_q, ce_d, we_q, we_d, ack_q, ack_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    rd_tag_t           iss_tag_q, iss_tag_d, ret_tag;
    logic              dvld_q, dvld_d, cvld_q, cvld_d;
    logic [DW-1:0]     ddata_q, ddata_d, cdata_q, cdata_d;

    always_comb begin
        slot_d    = I_line_start ? '0 : slot_q + SLOT_W'(1);
        owner     = (I_active && (slot_q < DISP_LIM)) ? OWN_DISP : OWN_CPU;
        // The ack cycle itself is never grantable, which forces the gap between CPU accesses.
        grant     = (owner == OWN_CPU) && I_cpu_req && !ack_q;
        ce_d      = 1'b0;
        we_d      = 1'b0;
        ack_d     = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        iss_tag_d = TAG_NONE;
        if (owner == OWN_DISP) begin
            ce_d      = 1'b1;
            addr_d    = I_disp_addr;
            iss_tag_d = TAG_DISP;
        end else if (grant) begin
            ce_d      = 1'b1;
            we_d      = I_cpu_we;
            ack_d     = 1'b1;
            addr_d    = I_cpu_addr;
            wdata_d   = I_cpu_wdata;
            iss_tag_d = I_cpu_we ? TAG_NONE : TAG_CPU;
        end
        dvld_d  = (ret_tag == TAG_DISP);
        cvld_d  = (ret_tag == TAG_CPU);
        ddata_d = dvld_d ? I_vram_rdata : ddata_q;
        cdata_d = cvld_d ? I_vram_rdata : cdata_q;
    end

    // The tag is taken from the strobe register so the pipe output meets data RD_LAT cycles later.
    fg_rd_tag_pipe #(
        .DEPTH (RD_LAT)
    ) u_tag_pipe (
        .clk_i  (I_pxl_clk),
        .rst_ni (I_rst_n),
        .tag_i  (iss_tag_q),
        .tag_o  (ret_tag)
    );

    always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            slot_q    <= '0;
            ce_q      <= 1'b0;
            we_q      <= 1'b0;
            ack_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            iss_tag_q <= TAG_NONE;
            dvld_q    <= 1'b0;
            cvld_q    <= 1'b0;
            ddata_q   <= '0;
            cdata_q   <= '0;
        end else begin
            slot_q    <= slot_d;
            ce_q      <= ce_d;
            we_q      <= we_d;
            ack_q     <= ack_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            iss_tag_q <= iss_tag_d;
            dvld_q    <= dvld_d;
            cvld_q    <= cvld_d;
            ddata_q   <= ddata_d;
            cdata_q   <= cdata_d;
        end
    end

    assign O_vram_ce    = ce_q;
    assign O_vram_we    = we_q;
    assign O_vram_addr  = addr_q;
    assign O_vram_wdata = wdata_q;
    assign O_cpu_ack    = ack_q;
    assign O_disp_valid = dvld_q;
    assign O_disp_data  = ddata_q;
    assign O_cpu_rvalid = cvld_q;
    assign O_cpu_rdata  = cdata_q;

endmodule
